qcmd_seq_ctrl: RTL and testbench

Shot sequencer for the qubit command generator. It drives the generator's `trig` input to restart command-memory playback once per shot, for a programmed number of shots. It times each shot window and counts the generator's `cstrobe` pulses to check each shot emitted the expected number of commands. It sits between the host register bank (start/abort/config) and the command generator.

---
 rtl/qcmd_seq_pkg.sv | 19 +
 rtl/qcmd_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_qcmd_seq_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/qcmd_seq_pkg.sv
// Shared definitions for the qubit command shot sequencer.
// Holds the FSM state encoding and the default bus widths used by qcmd_seq_ctrl.
// No logic; purely types and constants.
package qcmd_seq_pkg;

    // Default widths: command-memory address, shot counter, shot-window timer.
    localparam int unsigned AW_DEF  = 15;
    localparam int unsigned NSW_DEF = 16;
    localparam int unsigned TW_DEF  = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_REARM = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/qcmd_seq_ctrl.sv
// Shot sequencer: restarts the command generator once per shot via trig_o, times
// each shot window and counts cstrobe_i pulses against the expected command count.
// Latency: start_i at cycle N -> ARM at N+1, RUN at N+2; all outputs registered.
// Backpressure: none; start_i is ignored while busy, abort_i returns to IDLE from any state.
// Ports: clk_i/rst_i (sync, active-high); start_i/abort_i control pulses; nshots_i,
// shot_len_i, ncmd_i config latched at start; cstrobe_i from the generator;
// trig_o/busy_o/done_o status; shot_idx_o/cmd_cnt_o progress; err_* sticky flags.
module qcmd_seq_ctrl
    import qcmd_seq_pkg::*;
#(
    parameter int unsigned AW  = AW_DEF,
    parameter int unsigned NSW = NSW_DEF,
    parameter int unsigned TW  = TW_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [NSW-1:0]  nshots_i,
    input  logic [TW-1:0]   shot_len_i,
    input  logic [AW-3:0]   ncmd_i,
    input  logic            cstrobe_i,
    output logic            trig_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [NSW-1:0]  shot_idx_o,
    output logic [AW-3:0]   cmd_cnt_o,
    output logic            err_short_o,
    output logic            err_over_o,
    output logic            err_cfg_o
);

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    // Config is stored pre-decremented so the end-of-shot and last-shot compares
    // are plain equality against the running counters.
    logic [TW-1:0]   len_m1_q, len_m1_d;
    logic [NSW-1:0]  nshots_m1_q, nshots_m1_d;
    logic [AW-3:0]   ncmd_q, ncmd_d;
    logic [NSW-1:0]  shot_idx_q, shot_idx_d;
    logic [AW-3:0]   cmd_cnt_q, cmd_cnt_d;
    logic            err_short_q, err_short_d;
    logic            err_over_q, err_over_d;
    logic            err_cfg_q, err_cfg_d;
    logic            trig_q, trig_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [AW-3:0]   cnt_run;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        len_m1_d    = len_m1_q;
        nshots_m1_d = nshots_m1_q;
        ncmd_d      = ncmd_q;
        shot_idx_d  = shot_idx_q;
        cmd_cnt_d   = cmd_cnt_q;
        err_short_d = err_short_q;
        err_over_d  = err_over_q;
        err_cfg_d   = err_cfg_q;
        done_d      = 1'b0;
        cnt_run     = cmd_cnt_q;

        if (abort_i) begin
            // Abort wins over everything, including a simultaneous start;
            // counters and error flags are left as they are for inspection.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        len_m1_d    = shot_len_i - 1'b1;
                        nshots_m1_d = nshots_i - 1'b1;
                        ncmd_d      = ncmd_i;
                        shot_idx_d  = '0;
                        cmd_cnt_d   = '0;
                        timer_d     = '0;
                        err_short_d = 1'b0;
                        err_over_d  = 1'b0;
                        err_cfg_d   = 1'b0;
                        if ((nshots_i == '0) || (shot_len_i == '0)) begin
                            err_cfg_d = 1'b1;
                            state_d   = ST_DONE;
                            done_d    = 1'b1;
                        end else begin
                            state_d = ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    state_d = ST_RUN;
                    timer_d = '0;
                end
                ST_RUN: begin
                    timer_d = timer_q + 1'b1;
                    if (cstrobe_i) begin
                        if (cmd_cnt_q == ncmd_q) begin
                            err_over_d = 1'b1;
                        end else begin
                            cnt_run = cmd_cnt_q + 1'b1;
                        end
                    end
                    cmd_cnt_d = cnt_run;
                    if (timer_q == len_m1_q) begin
                        // A strobe landing in the final window cycle still counts.
                        if (cnt_run < ncmd_q) begin
                            err_short_d = 1'b1;
                        end
                        if (shot_idx_q == nshots_m1_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = ST_REARM;
                            shot_idx_d = shot_idx_q + 1'b1;
                            cmd_cnt_d  = '0;
                        end
                    end
                end
                ST_REARM: begin
                    // Strobes seen while the generator is parked are dropped.
                    state_d = ST_RUN;
                    timer_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        trig_d = (state_d != ST_RUN);
        busy_d = (state_d == ST_ARM) || (state_d == ST_RUN) || (state_d == ST_REARM);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            len_m1_q    <= '0;
            nshots_m1_q <= '0;
            ncmd_q      <= '0;
            shot_idx_q  <= '0;
            cmd_cnt_q   <= '0;
            err_short_q <= 1'b0;
            err_over_q  <= 1'b0;
            err_cfg_q   <= 1'b0;
            trig_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            len_m1_q    <= len_m1_d;
            nshots_m1_q <= nshots_m1_d;
            ncmd_q      <= ncmd_d;
            shot_idx_q  <= shot_idx_d;
            cmd_cnt_q   <= cmd_cnt_d;
            err_short_q <= err_short_d;
            err_over_q  <= err_over_d;
            err_cfg_q   <= err_cfg_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign trig_o      = trig_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign shot_idx_o  = shot_idx_q;
    assign cmd_cnt_o   = cmd_cnt_q;
    assign err_short_o = err_short_q;
    assign err_over_o  = err_over_q;
    assign err_cfg_o   = err_cfg_q;

endmodule

// File: tb/tb_qcmd_seq_ctrl.sv
// Directed testbench for qcmd_seq_ctrl: normal runs, short/over command counts,
// abort, invalid config, start+abort collision and reset during REARM.
module tb_qcmd_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] nshots;
    logic [23:0] shot_len;
    logic [12:0] ncmd;
    logic        cstrobe;
    logic        trig;
    logic        busy;
    logic        done;
    logic [15:0] shot_idx;
    logic [12:0] cmd_cnt;
    logic        err_short;
    logic        err_over;
    logic        err_cfg;

    int total = 0;
    int bad   = 0;

    // Results of the most recent run() call.
    int   r_done_at;
    int   r_trig_cnt;
    logic r_trig2;
    logic r_samp_short;
    logic r_k_trig, r_k_busy, r_k_done, r_k_short;
    logic [15:0] r_k_idx;
    logic [12:0] r_k_cnt;
    int   r_late_done;

    qcmd_seq_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .abort_i     (abort),
        .nshots_i    (nshots),
        .shot_len_i  (shot_len),
        .ncmd_i      (ncmd),
        .cstrobe_i   (cstrobe),
        .trig_o      (trig),
        .busy_o      (busy),
        .done_o      (done),
        .shot_idx_o  (shot_idx),
        .cmd_cnt_o   (cmd_cnt),
        .err_short_o (err_short),
        .err_over_o  (err_over),
        .err_cfg_o   (err_cfg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start with the given config and drives cstrobe from a per-shot
    // bitmask indexed by the RUN-window cycle. t counts cycles after the start
    // edge (t=1 is ARM). Optional abort/reset at a given t; snapshot taken at kill+1.
    task automatic run(input int nsh, input int len, input int nc,
                       input logic [15:0] m0, input logic [15:0] m1, input logic [15:0] m2,
                       input int abort_at, input int rst_at, input int samp_t);
        int kill;
        int k;
        int s;
        logic [15:0] m;
        kill         = (abort_at > rst_at) ? abort_at : rst_at;
        r_done_at    = 0;
        r_trig_cnt   = 0;
        r_trig2      = 1'b1;
        r_samp_short = 1'b0;
        r_late_done  = 0;
        nshots   = nsh[15:0];
        shot_len = len[23:0];
        ncmd     = nc[12:0];
        start    = 1'b1;
        step();
        start    = 1'b0;
        for (int t = 1; t <= 300; t++) begin
            if (done && r_done_at == 0) r_done_at = t;
            if (done && kill != 0) r_late_done++;
            if (trig && busy) r_trig_cnt++;
            if (t == 2) r_trig2 = trig;
            if (t == samp_t) r_samp_short = err_short;
            if (kill != 0 && t == kill + 1) begin
                r_k_trig  = trig;
                r_k_busy  = busy;
                r_k_done  = done;
                r_k_short = err_short;
                r_k_idx   = shot_idx;
                r_k_cnt   = cmd_cnt;
            end
            if (kill == 0 && r_done_at != 0) break;
            if (kill != 0 && t >= kill + 4) break;
            cstrobe = 1'b0;
            if (t >= 2) begin
                k = (t - 2) % (len + 1);
                s = (t - 2) / (len + 1);
                m = (s == 0) ? m0 : ((s == 1) ? m1 : m2);
                if (k < len && k < 16) cstrobe = m[k];
            end
            if (kill != 0 && t >= kill) cstrobe = 1'b0;
            abort = (t == abort_at);
            rst   = (t == rst_at);
            step();
        end
        cstrobe = 1'b0;
        abort   = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        nshots   = '0;
        shot_len = '0;
        ncmd     = '0;
        cstrobe  = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_trig", trig, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", shot_idx, 0);
        chk("rst_cnt", cmd_cnt, 0);
        chk("rst_errs", {err_short, err_over, err_cfg}, 0);

        // Normal run: 3 shots of 10 cycles, 2 strobes each
        run(3, 10, 2, 16'h0024, 16'h0024, 16'h0024, 0, 0, 0);
        chk("n_trig_run", r_trig2, 0);
        chk("n_trig_hi", r_trig_cnt, 3);
        chk("n_done_at", r_done_at, 34);
        chk("n_busy", busy, 0);
        chk("n_trig_done", trig, 1);
        chk("n_idx", shot_idx, 2);
        chk("n_cnt", cmd_cnt, 2);
        chk("n_errs", {err_short, err_over, err_cfg}, 0);
        step();
        chk("n_done_pulse", done, 0);

        // Short shot 1: ncmd=3, shot 1 only gets 2 strobes
        run(3, 10, 3, 16'h002A, 16'h000A, 16'h002A, 0, 0, 23);
        chk("s_short_after1", r_samp_short, 1);
        chk("s_done_at", r_done_at, 34);
        chk("s_short_end", err_short, 1);
        chk("s_over", err_over, 0);

        // Over-count: ncmd=1 with 2 strobes, single shot
        run(1, 10, 1, 16'h000A, 16'h0000, 16'h0000, 0, 0, 0);
        chk("o_done_at", r_done_at, 12);
        chk("o_over", err_over, 1);
        chk("o_cnt_hold", cmd_cnt, 1);
        chk("o_short_clr", err_short, 0);

        // Abort during RUN of shot 1 (window cycle 4)
        run(3, 10, 2, 16'h0024, 16'h0024, 16'h0024, 17, 0, 0);
        chk("a_busy", r_k_busy, 0);
        chk("a_trig", r_k_trig, 1);
        chk("a_done", r_k_done, 0);
        chk("a_idx", r_k_idx, 1);
        chk("a_cnt", r_k_cnt, 1);
        chk("a_no_done", r_late_done, 0);

        // Invalid config: nshots=0
        nshots   = 16'd0;
        shot_len = 24'd10;
        start    = 1'b1;
        step();
        start    = 1'b0;
        chk("c_done", done, 1);
        chk("c_err_cfg", err_cfg, 1);
        chk("c_busy", busy, 0);
        step();
        chk("c_done_pulse", done, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        // start and abort together in IDLE: abort wins, flags untouched
        nshots = 16'd2;
        start  = 1'b1;
        abort  = 1'b1;
        step();
        start  = 1'b0;
        abort  = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_cfg_held", err_cfg, 1);
        step();
        chk("sa_busy2", busy, 0);
        chk("sa_trig", trig, 1);

        // Invalid config: shot_len=0
        nshots   = 16'd1;
        shot_len = 24'd0;
        start    = 1'b1;
        step();
        start    = 1'b0;
        chk("z_done", done, 1);
        chk("z_err_cfg", err_cfg, 1);
        step();

        // Reset while in REARM (t=7 for shot_len=5); err_short already set
        run(2, 5, 2, 16'h0002, 16'h0002, 16'h0002, 0, 7, 7);
        chk("r_short_pre", r_samp_short, 1);
        chk("r_trig", r_k_trig, 1);
        chk("r_busy", r_k_busy, 0);
        chk("r_idx", r_k_idx, 0);
        chk("r_cnt", r_k_cnt, 0);
        chk("r_short", r_k_short, 0);

        // Normal run after reset
        run(2, 5, 1, 16'h0002, 16'h0004, 16'h0000, 0, 0, 0);
        chk("p_done_at", r_done_at, 13);
        chk("p_idx", shot_idx, 1);
        chk("p_errs", {err_short, err_over, err_cfg}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
